// File: rtl/imem_loader_pkg.sv
// imem_loader shared definitions.
// Loader FSM state encodings and the byte-per-word constant.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_timeout.sv
// loader_timeout: loadable down-counter for inter-byte timeout.
// Ports: clk, reset, clr (reload), en (count), expired (Nth idle cycle).
module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam bit ENABLED = (TIMEOUT_CYCLES != 0);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= LOAD;
        end else if (en && cnt != '0) begin
            cnt <= cnt - ONE;
        end
    end

    // Fires during the idle cycle that completes the allowed budget.
    // Independent of clr so the FSM can give a transfer priority.
    assign expired = ENABLED && en && (cnt == ONE);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: byte stream to instruction memory write port.
// Ports: start/rx stream in; mem_we/addr/wdata out; busy/done/error status.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH          = 256,
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);
    localparam logic [1:0]  LAST_IDX = 2'(BYTES_PER_WORD - 1);

    state_t      state, state_n;
    logic [15:0] len;
    logic [15:0] len_full;
    logic [1:0]  idx;
    logic        xfer;
    logic        tmo_en, tmo_clr, tmo_exp;
    logic [ADDR_W:0] wl_inc;
    logic [15:0] wl_ext;

    assign xfer     = rx_valid & rx_ready;
    assign len_full = {rx_data, len[7:0]};
    assign wl_inc   = words_loaded + 1'b1;
    assign wl_ext   = 16'(wl_inc);

    always_comb begin
        rx_ready = 1'b0;
        mem_we   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        unique case (state)
            S_LEN_LO, S_LEN_HI, S_DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
            S_WRITE: begin
                mem_we = 1'b1;
                busy   = 1'b1;
            end
            S_DONE: done = 1'b1;
            S_ERR:  error = 1'b1;
            default: ;
        endcase
    end

    assign tmo_en  = rx_ready;
    assign tmo_clr = xfer | (state_n != state);

    loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clr    (tmo_clr),
        .en     (tmo_en),
        .expired(tmo_exp)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_n = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (xfer)         state_n = S_LEN_HI;
                else if (tmo_exp) state_n = S_ERR;
            end
            S_LEN_HI: begin
                if (xfer) begin
                    if (len_full == 16'd0)
                        state_n = S_DONE;
                    else if ({1'b0, len_full} > DEPTH_L)
                        state_n = S_ERR;
                    else
                        state_n = S_DATA;
                end else if (tmo_exp) begin
                    state_n = S_ERR;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    if (idx == LAST_IDX) state_n = S_WRITE;
                end else if (tmo_exp) begin
                    state_n = S_ERR;
                end
            end
            S_WRITE: begin
                if (wl_ext == len) state_n = S_DONE;
                else               state_n = S_DATA;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr     <= '0;
            mem_wdata    <= '0;
            words_loaded <= '0;
            idx          <= '0;
            len          <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        mem_addr     <= '0;
                        words_loaded <= '0;
                        idx          <= '0;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) len[7:0] <= rx_data;
                end
                S_LEN_HI: begin
                    if (xfer) len[15:8] <= rx_data;
                end
                S_DATA: begin
                    if (xfer) begin
                        mem_wdata[{idx, 3'b000} +: 8] <= rx_data;
                        idx <= idx + 2'd1;
                    end
                end
                S_WRITE: begin
                    mem_addr     <= mem_addr + 1'b1;
                    words_loaded <= wl_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed table-driven bench for imem_loader.
// Shadow-checks every write; hand sequences cover timing corners.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready, mem_we, busy, done, error;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [8:0]  words_loaded;

    int errors = 0;
    int checks = 0;
    int wr_count = 0;
    int last_addr = -1;

    always #5 clk = ~clk;

    imem_loader #(
        .DEPTH(256), .ADDR_W(8), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    typedef struct {
        logic [15:0] hdr;
        int          nwords;
        bit          gaps;
        bit          exp_done;
        bit          exp_err;
        int          exp_words;
    } vec_t;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] gen(input int k);
        logic [7:0] kb;
        kb = 8'(k);
        if (k == 0) return 32'h00500113;
        if (k == 1) return 32'h00C00193;
        return {kb, 8'hA5, ~kb, kb ^ 8'h3C};
    endfunction

    always @(negedge clk) begin
        if (mem_we) begin
            chk("wr_addr", 32'(mem_addr), 32'(wr_count));
            chk("wr_data", mem_wdata, gen(wr_count));
            chk("wr_ready_low", 32'(rx_ready), 32'd0);
            last_addr = int'(mem_addr);
            wr_count++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 32'(n), 32'd0);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_words(input int first, input int cnt,
                              input bit gaps);
        logic [31:0] w;
        for (int k = first; k < first + cnt; k++) begin
            w = gen(k);
            send_byte(w[7:0], gaps);
            send_byte(w[15:8], gaps);
            send_byte(w[23:16], gaps);
            send_byte(w[31:24], gaps);
        end
    endtask

    task automatic begin_load(input logic [15:0] hdr, input bit gaps);
        wr_count  = 0;
        last_addr = -1;
        pulse_start();
        send_byte(hdr[7:0], gaps);
        send_byte(hdr[15:8], gaps);
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(done || error) && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) chk("end_timeout", 32'(n), 32'd0);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{16'd2,     2,   1'b0, 1'b1, 1'b0, 2};
        vecs[1] = '{16'd2,     2,   1'b1, 1'b1, 1'b0, 2};
        vecs[2] = '{16'd0,     0,   1'b0, 1'b1, 1'b0, 0};
        vecs[3] = '{16'd256,   256, 1'b0, 1'b1, 1'b0, 256};
        vecs[4] = '{16'd257,   0,   1'b0, 1'b0, 1'b1, 0};
        vecs[5] = '{16'd5,     5,   1'b1, 1'b1, 1'b0, 5};
        vecs[6] = '{16'd1,     1,   1'b0, 1'b1, 1'b0, 1};
        vecs[7] = '{16'hFFFF,  0,   1'b0, 1'b0, 1'b1, 0};
        vecs[8] = '{16'd3,     3,   1'b1, 1'b1, 1'b0, 3};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);

        // Basic load with exact write/done timing.
        begin_load(16'd2, 1'b0);
        chk("basic_busy", 32'(busy), 32'd1);
        send_words(0, 2, 1'b0);
        chk("basic_we_lat", 32'(mem_we), 32'd1);
        chk("basic_we_addr", 32'(mem_addr), 32'd1);
        chk("basic_done_early", 32'(done), 32'd0);
        @(negedge clk);
        chk("basic_done", 32'(done), 32'd1);
        chk("basic_busy_end", 32'(busy), 32'd0);
        chk("basic_words", 32'(words_loaded), 32'd2);
        chk("basic_wr_cnt", 32'(wr_count), 32'd2);

        for (int i = 0; i < 9; i++) begin
            begin_load(vecs[i].hdr, vecs[i].gaps);
            send_words(0, vecs[i].nwords, vecs[i].gaps);
            wait_end();
            @(negedge clk);
            chk($sformatf("v%0d_done", i), 32'(done),
                32'(vecs[i].exp_done));
            chk($sformatf("v%0d_err", i), 32'(error),
                32'(vecs[i].exp_err));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
            chk($sformatf("v%0d_words", i), 32'(words_loaded),
                32'(vecs[i].exp_words));
            chk($sformatf("v%0d_wr_cnt", i), 32'(wr_count),
                32'(vecs[i].exp_words));
            chk($sformatf("v%0d_last", i), 32'(last_addr),
                32'(vecs[i].exp_words - 1));
        end

        // Timeout: stall mid-word.
        begin_load(16'd1, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h01, 1'b0);
        repeat (15) @(negedge clk);
        chk("tmo_not_yet", 32'(error), 32'd0);
        chk("tmo_busy_yet", 32'(busy), 32'd1);
        @(negedge clk);
        chk("tmo_error", 32'(error), 32'd1);
        chk("tmo_busy", 32'(busy), 32'd0);
        chk("tmo_no_we", 32'(wr_count), 32'd0);
        begin_load(16'd2, 1'b0);
        chk("tmo_restart_err", 32'(error), 32'd0);
        send_words(0, 2, 1'b0);
        wait_end();
        chk("tmo_reload_done", 32'(done), 32'd1);
        chk("tmo_reload_wr", 32'(wr_count), 32'd2);

        // Reset mid-load after two data bytes.
        begin_load(16'd1, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h01, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mrst_ready", 32'(rx_ready), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_addr", 32'(mem_addr), 32'd0);
        chk("mrst_wdata", mem_wdata, 32'd0);
        chk("mrst_words", 32'(words_loaded), 32'd0);
        repeat (3) @(negedge clk);
        chk("mrst_idle", 32'(rx_ready), 32'd0);
        chk("mrst_no_we", 32'(wr_count), 32'd0);
        begin_load(16'd1, 1'b0);
        send_words(0, 1, 1'b0);
        wait_end();
        chk("mrst_reload_done", 32'(done), 32'd1);
        chk("mrst_reload_last", 32'(last_addr), 32'd0);

        // start pulsed while busy in DATA.
        begin_load(16'd2, 1'b0);
        send_words(0, 1, 1'b0);
        send_byte(8'h93, 1'b0);
        send_byte(8'h01, 1'b0);
        pulse_start();
        chk("sbusy_busy", 32'(busy), 32'd1);
        send_byte(8'hC0, 1'b0);
        send_byte(8'h00, 1'b0);
        wait_end();
        chk("sbusy_done", 32'(done), 32'd1);
        chk("sbusy_words", 32'(words_loaded), 32'd2);
        chk("sbusy_wr", 32'(wr_count), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: sim time limit hit");
        $fatal(1);
    end

endmodule
